mem_port_arbiter: RTL and testbench

- Shares the single-ported memory2c instance between the fetch-stage instruction requester (IF) and the memory-stage data requester (DM).
- Sequences each access through a fixed multi-cycle window of LATENCY cycles.
- Returns read data and a done pulse to the requester, and drives a per-requester stall back to the pipeline.
- Also sequences the end-of-program memory dump request.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_lat_cnt.sv | 33 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : state/grant types and default sizing for mem_port_arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_t;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/mem_lat_cnt.sv
`default_nettype none
// ============================================================================
// mem_lat_cnt : loadable down-counter with zero flag, used for access timing
// Revision    : 1.0
// ============================================================================
module mem_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at zero so a stray dec can never wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory2c port between IF and DM requesters
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        dump_req,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_dump,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        err
);

    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(LATENCY - 1);

    arb_state_t r_state;
    grant_t     r_grant;
    logic       r_dump_sent;
    logic       w_dm_req;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_zero;

    assign w_dm_req   = dm_rd | dm_wr;
    assign w_cnt_load = (r_state == IDLE) && (w_dm_req || if_req);
    assign w_cnt_dec  = (r_state == ACCESS);

    mem_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (c_load_val),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    assign if_stall = if_req & ~if_done;
    assign dm_stall = w_dm_req & ~dm_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= GNT_NONE;
            r_dump_sent <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 16'h0000;
            mem_dump    <= 1'b0;
            if_rdata    <= 16'h0000;
            if_done     <= 1'b0;
            dm_rdata    <= 16'h0000;
            dm_done     <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_dump <= 1'b0;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            err      <= 1'b0;
            // One dump pulse per assertion of dump_req, re-armed once it drops.
            if (!dump_req) begin
                r_dump_sent <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    err <= dm_rd & dm_wr;
                    if (w_dm_req) begin
                        r_grant   <= GNT_DM;
                        r_state   <= ACCESS;
                        mem_en    <= 1'b1;
                        mem_wr    <= dm_wr;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        r_grant  <= GNT_IF;
                        r_state  <= ACCESS;
                        mem_en   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_addr <= if_addr;
                    end else if (dump_req && !r_dump_sent) begin
                        mem_dump    <= 1'b1;
                        r_dump_sent <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (w_cnt_zero) begin
                        mem_en  <= 1'b0;
                        mem_wr  <= 1'b0;
                        r_state <= DONE;
                        if (r_grant == GNT_DM) begin
                            dm_done <= 1'b1;
                            if (!mem_wr) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                    mem_en  <= 1'b0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : randomized scoreboard bench for mem_port_arbiter
// Revision            : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int L = DEF_LATENCY;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_rd, dm_wr, dump_req;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_dump, if_done, if_stall, dm_done, dm_stall, err;
    logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

    mem_port_arbiter #(.LATENCY(L), .CNT_W(DEF_CNT_W)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dump_req(dump_req), .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dump(mem_dump),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory2c stand-in: combinational read, write while enabled.
    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    logic [15:0] mem_arr [256];
    bit          mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            mem_inited <= 1'b1;
        end else if (mem_en && mem_wr) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_arr[mem_addr[7:0]];

    typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; int start; } acc_t;
    typedef struct { logic is_dm; logic is_read; logic [15:0] rdata; int at; } done_t;

    acc_t  q_acc[$];
    done_t q_done[$];
    int    q_err[$];
    int    q_dump[$];

    logic [15:0] ref_mem [256];
    logic [15:0] last_dm_rd = 16'h0;
    int model_free = 0;
    int if_done_at = -1;
    int dm_done_at = -1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows an event.
    bit    in_acc = 1'b0;
    int    acc_len = 0;
    acc_t  cur;
    done_t dq;
    int    eq;
    always @(negedge clk) begin
        if (rst) begin
            in_acc = 1'b0;
        end else begin
            chk("if_stall", if_stall, if_req && (cyc != if_done_at));
            chk("dm_stall", dm_stall, (dm_rd || dm_wr) && (cyc != dm_done_at));
            chk("wr_implies_en", mem_wr & ~mem_en, 0);
            chk("done_overlap", if_done & dm_done, 0);
            if (mem_en) begin
                if (!in_acc) begin
                    in_acc  = 1'b1;
                    acc_len = 1;
                    chk("pending_access", q_acc.size() > 0, 1);
                    if (q_acc.size() > 0) begin
                        cur = q_acc.pop_front();
                        chk("acc_start", cyc, cur.start);
                    end else begin
                        cur = '{mem_wr, mem_addr, mem_wdata, cyc};
                    end
                end else begin
                    acc_len++;
                end
                chk("acc_wr", mem_wr, cur.wr);
                chk("acc_addr", mem_addr, cur.addr);
                if (cur.wr) chk("acc_wdata", mem_wdata, cur.wdata);
            end else if (in_acc) begin
                chk("acc_len", acc_len, L);
                in_acc = 1'b0;
            end
            if (if_done || dm_done) begin
                chk("pending_done", q_done.size() > 0, 1);
                if (q_done.size() > 0) begin
                    dq = q_done.pop_front();
                    chk("done_who", dm_done, dq.is_dm);
                    chk("done_cyc", cyc, dq.at);
                    if (dq.is_dm) chk("dm_rdata", dm_rdata, dq.rdata);
                    else          chk("if_rdata", if_rdata, dq.rdata);
                end
            end else if (q_done.size() > 0 && q_done[0].at < cyc) begin
                dq = q_done.pop_front();
                chk("done_missed", cyc, dq.at);
            end
            if (err) begin
                chk("pending_err", q_err.size() > 0, 1);
                if (q_err.size() > 0) begin eq = q_err.pop_front(); chk("err_cyc", cyc, eq); end
            end else if (q_err.size() > 0 && q_err[0] < cyc) begin
                eq = q_err.pop_front();
                chk("err_missed", cyc, eq);
            end
            if (mem_dump) begin
                chk("pending_dump", q_dump.size() > 0, 1);
                if (q_dump.size() > 0) begin eq = q_dump.pop_front(); chk("dump_cyc", cyc, eq); end
            end else if (q_dump.size() > 0 && q_dump[0] < cyc) begin
                eq = q_dump.pop_front();
                chk("dump_missed", cyc, eq);
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int x);
        if (cyc < x) begin
            while (cyc < x) @(negedge clk);
            #2;
        end
    endtask

    // kind: 0 IF rd, 1 DM rd, 2 DM wr, 3 DM rd+wr, 4 IF+DM rd, 5 IF+DM wr
    task automatic issue(input int kind, input logic [15:0] ia, input logic [15:0] da,
                         input logic [15:0] wd, input bit early, input bit scram);
        int g, gi, ddm, dif;
        bit has_dm, has_if, wr;
        has_dm = (kind != 0);
        has_if = (kind == 0) || (kind >= 4);
        wr     = (kind == 2) || (kind == 3) || (kind == 5);
        g   = (cyc + 1 > model_free) ? cyc + 1 : model_free;
        ddm = -1;
        dif = -1;
        if (has_dm) begin
            q_acc.push_back('{wr, da, wd, g});
            if (wr) ref_mem[da[7:0]] = wd;
            else    last_dm_rd = ref_mem[da[7:0]];
            ddm = g + L;
            q_done.push_back('{1'b1, !wr, last_dm_rd, ddm});
            if (kind == 3) q_err.push_back(g);
            dm_done_at = ddm;
        end
        if (has_if) begin
            gi  = has_dm ? ddm + 2 : g;
            dif = gi + L;
            q_acc.push_back('{1'b0, ia, 16'h0, gi});
            q_done.push_back('{1'b0, 1'b1, ref_mem[ia[7:0]], dif});
            if_done_at = dif;
        end
        model_free = (has_if ? dif : ddm) + 2;
        if_req   = has_if;
        if_addr  = ia;
        dm_rd    = (kind == 1) || (kind == 3) || (kind == 4);
        dm_wr    = wr;
        dm_addr  = da;
        dm_wdata = wd;
        if (has_dm && has_if) begin
            wait_cyc(ddm);
            dm_rd = 1'b0;
            dm_wr = 1'b0;
            wait_cyc(dif);
            if_req = 1'b0;
        end else begin
            wait_cyc(g);
            if (scram) begin
                if_addr  = 16'($urandom);
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
            if (early) begin
                if_req = 1'b0;
                dm_rd  = 1'b0;
                dm_wr  = 1'b0;
            end
            wait_cyc(has_if ? dif : ddm);
            if_req = 1'b0;
            dm_rd  = 1'b0;
            dm_wr  = 1'b0;
        end
    endtask

    task automatic do_dump(input int hold, input bit with_if, input logic [15:0] ia);
        int g, dif;
        g = (cyc + 1 > model_free) ? cyc + 1 : model_free;
        dump_req = 1'b1;
        if (with_if) begin
            dif = g + L;
            q_acc.push_back('{1'b0, ia, 16'h0, g});
            q_done.push_back('{1'b0, 1'b1, ref_mem[ia[7:0]], dif});
            if_done_at = dif;
            model_free = dif + 2;
            q_dump.push_back(model_free);
            if_req  = 1'b1;
            if_addr = ia;
            wait_cyc(dif);
            if_req = 1'b0;
            wait_cyc(model_free + hold - 1);
        end else begin
            q_dump.push_back(g);
            wait_cyc(g + hold - 1);
        end
        dump_req = 1'b0;
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_dump"}, mem_dump, 0);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_dm_done"}, dm_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
    endtask

    task automatic reset_mid_access();
        int g;
        g = (cyc + 1 > model_free) ? cyc + 1 : model_free;
        q_acc.push_back('{1'b0, 16'h0123, 16'h0, g});
        if_done_at = g + L;
        if_req  = 1'b1;
        if_addr = 16'h0123;
        wait_cyc(g);
        chk("rst_pre_mem_en", mem_en, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        q_acc.delete();
        q_done.delete();
        q_err.delete();
        q_dump.delete();
        if_req     = 1'b0;
        model_free = 0;
        last_dm_rd = 16'h0;
        if_done_at = -1;
        dm_done_at = -1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            chk("idle_mem_en", mem_en, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst = 1'b1; if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; dump_req = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
        repeat (3) next_cycle();
        check_all_zero("reset");
        rst = 1'b0;
        next_cycle();

        issue(0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0);
        issue(4, 16'h0030, 16'h0200, 16'h0000, 1'b0, 1'b0);
        issue(2, 16'h0000, 16'h0040, 16'h1234, 1'b0, 1'b0);
        issue(1, 16'h0000, 16'h0040, 16'h0000, 1'b0, 1'b0);
        issue(2, 16'h0000, 16'h0041, 16'h5678, 1'b0, 1'b0);
        issue(3, 16'h0000, 16'h0050, 16'hBEEF, 1'b0, 1'b0);
        issue(0, 16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_dump(3, 1'b0, 16'h0000);
        do_dump(2, 1'b1, 16'h0010);
        reset_mid_access();

        for (int n = 0; n < 80; n++) begin
            int kind;
            repeat ($urandom_range(0, 3)) next_cycle();
            kind = $urandom_range(0, 6);
            if (kind == 6)
                do_dump($urandom_range(1, 4), 1'($urandom_range(0, 1)), 16'($urandom));
            else
                issue(kind, 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        wait_cyc(model_free + 4);
        chk("leftover_acc", q_acc.size(), 0);
        chk("leftover_done", q_done.size(), 0);
        chk("leftover_err", q_err.size(), 0);
        chk("leftover_dump", q_dump.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
